// File: rtl/cordic_vec.sv
// cordic_vec: iterative CORDIC vectoring engine, one micro-rotation per clock, returning atan2 angle and magnitude.
// Optional macro CORDIC_VEC_GAIN_COMP_EN adds a GAIN state that scales mag by 1/K so it reads in input units.
module cordic_vec #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [0:15] cos_in,
  input  logic [0:15] sine_in,
  output logic        busy,
  output logic        done,
  output logic [0:15] theta,
  output logic [0:16] mag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_GAIN,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_I = 5'(ITER - 1);

  state_t             state_q, state_d;
  logic signed [17:0] x_q, x_d;
  logic signed [17:0] y_q, y_d;
  logic        [15:0] z_q, z_d;
  logic        [4:0]  i_q, i_d;
  logic               zeroFlag_q, zeroFlag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic        [15:0] theta_q, theta_d;
  logic        [16:0] mag_q, mag_d;

  logic signed [17:0] cosExt, sineExt;
  logic signed [17:0] xShift, yShift;

  // Arctangent of 2^-i in binary-angle units (65536 per turn).
  function automatic logic [15:0] atanEntry(input logic [4:0] idx);
    logic [15:0] a;
    case (idx)
      5'd0:    a = 16'd8192;
      5'd1:    a = 16'd4836;
      5'd2:    a = 16'd2555;
      5'd3:    a = 16'd1297;
      5'd4:    a = 16'd651;
      5'd5:    a = 16'd326;
      5'd6:    a = 16'd163;
      5'd7:    a = 16'd81;
      5'd8:    a = 16'd41;
      5'd9:    a = 16'd20;
      5'd10:   a = 16'd10;
      5'd11:   a = 16'd5;
      5'd12:   a = 16'd3;
      5'd13:   a = 16'd1;
      5'd14:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

  assign cosExt  = {{2{cos_in[0]}}, cos_in};
  assign sineExt = {{2{sine_in[0]}}, sine_in};
  assign xShift  = x_q >>> i_q;
  assign yShift  = y_q >>> i_q;

`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic [34:0] gainProd;
  // 39797 is 1/K in Q0.16; the added half-LSB rounds to nearest.
  assign gainProd = 35'(unsigned'(x_q)) * 35'd39797 + 35'd32768;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
      zeroFlag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      theta_q    <= '0;
      mag_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      i_q        <= i_d;
      zeroFlag_q <= zeroFlag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      theta_q    <= theta_d;
      mag_q      <= mag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    i_d        = i_q;
    zeroFlag_d = zeroFlag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    theta_d    = theta_q;
    mag_d      = mag_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Fold left half-plane vectors into the right half-plane and start z at 180 degrees.
          if (cosExt < 0) begin
            x_d = -cosExt;
            y_d = -sineExt;
            z_d = 16'h8000;
          end else begin
            x_d = cosExt;
            y_d = sineExt;
            z_d = 16'h0000;
          end
          i_d        = '0;
          zeroFlag_d = (cosExt == 18'sd0) && (sineExt == 18'sd0);
          busy_d     = 1'b1;
          state_d    = S_ITER;
        end
      end
      S_ITER: begin
        if (!y_q[17]) begin
          x_d = x_q + yShift;
          y_d = y_q - xShift;
          z_d = z_q + atanEntry(i_q);
        end else begin
          x_d = x_q - yShift;
          y_d = y_q + xShift;
          z_d = z_q - atanEntry(i_q);
        end
        i_d = i_q + 5'd1;
        if (i_q == LAST_I) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
          state_d = S_GAIN;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_GAIN: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
        x_d     = signed'(18'(gainProd >> 16));
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        theta_d = zeroFlag_q ? 16'h0000 : z_q;
        mag_d   = zeroFlag_q ? 17'd0 : x_q[16:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign theta = theta_q;
  assign mag   = mag_q;

endmodule

// File: tb/tb_cordic_vec.sv
// tb_cordic_vec: directed self-checking bench for cordic_vec (angle, magnitude, latency and control behaviour).
module tb_cordic_vec;

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int LAT      = 18;
  localparam int BUSY_CYC = 18;
  localparam int THRU     = 19;
  localparam int MAG_AX   = 16384;
  localparam int MAG_DIAG = 23170;
  localparam int MAG_EXT  = 32768;
`else
  localparam int LAT      = 17;
  localparam int BUSY_CYC = 17;
  localparam int THRU     = 18;
  localparam int MAG_AX   = 26981;
  localparam int MAG_DIAG = 38155;
  localparam int MAG_EXT  = 53961;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [0:15] cos_in;
  logic [0:15] sine_in;
  logic        busy;
  logic        done;
  logic [0:15] theta;
  logic [0:16] mag;

  int checks   = 0;
  int failures = 0;

  cordic_vec #(.ITER(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cos_in  (cos_in),
    .sine_in (sine_in),
    .busy    (busy),
    .done    (done),
    .theta   (theta),
    .mag     (mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Tolerance compare; angles are compared modulo 2^16 so 0x0000 +/- 4 wraps correctly.
  task automatic checkNear(input string tag, input int observed, input int expected, input int tol, input bit wrap16);
    int d;
    logic signed [15:0] d16;
    if (wrap16) begin
      d16 = 16'(observed - expected);
      d   = int'(d16);
    end else begin
      d = observed - expected;
    end
    if (d < 0) d = -d;
    checks++;
    assert ((d <= tol) === 1'b1) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
    end
  endtask

  // Starts one operation from IDLE and waits (bounded) for done; returns edges to done and busy cycles seen.
  task automatic applyStimulus(input logic signed [15:0] c, input logic signed [15:0] s,
                               output int lat, output int busyCnt);
    cos_in  = c;
    sine_in = s;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    busyCnt = 0;
    if (busy) busyCnt++;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busyCnt++;
    end
  endtask

  initial begin
    int lat, bc;
    int vc[3], vs[3], vt[3];
    int accCyc[3];
    int nAcc, nDone, cyc, doneSeen;
    bit prevBusy, prevDone, dbl;

    rst_n   = 1'b0;
    start   = 1'b0;
    cos_in  = '0;
    sine_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_theta", int'(theta), 0);
    checkOutput("reset_mag", int'(mag), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'sd16384, 16'sd0, lat, bc);
    checkOutput("q1_latency", lat, LAT);
    checkOutput("q1_busy_cycles", bc, BUSY_CYC);
    checkNear("q1_theta", int'(theta), 32'h0000, 4, 1'b1);
    checkNear("q1_mag", int'(mag), MAG_AX, MAG_AX / 1000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("q1_done_falls", int'(done), 0);

    applyStimulus(16'sd0, 16'sd16384, lat, bc);
    checkOutput("deg90_latency", lat, LAT);
    checkOutput("deg90_busy_cycles", bc, BUSY_CYC);
    checkNear("deg90_theta", int'(theta), 32'h4000, 4, 1'b1);
    checkNear("deg90_mag", int'(mag), MAG_AX, MAG_AX / 1000, 1'b0);
    @(posedge clk);
    #1;

    applyStimulus(-16'sd16384, -16'sd16384, lat, bc);
    checkOutput("q3_latency", lat, LAT);
    checkNear("q3_theta", int'(theta), 32'hA000, 4, 1'b1);
    checkNear("q3_mag", int'(mag), MAG_DIAG, MAG_DIAG / 1000, 1'b0);
    cos_in  = 16'sd1234;
    sine_in = -16'sd777;
    repeat (4) @(posedge clk);
    #1;
    checkNear("q3_theta_hold", int'(theta), 32'hA000, 4, 1'b1);
    checkNear("q3_mag_hold", int'(mag), MAG_DIAG, MAG_DIAG / 1000, 1'b0);

    applyStimulus(-16'sd32768, 16'sd0, lat, bc);
    checkOutput("ext_latency", lat, LAT);
    checkNear("ext_theta", int'(theta), 32'h8000, 4, 1'b1);
    checkNear("ext_mag", int'(mag), MAG_EXT, MAG_EXT / 1000, 1'b0);
    @(posedge clk);
    #1;

    applyStimulus(16'sd0, 16'sd0, lat, bc);
    checkOutput("zero_latency", lat, LAT);
    checkOutput("zero_theta", int'(theta), 0);
    checkOutput("zero_mag", int'(mag), 0);
    @(posedge clk);
    #1;

    // start held high through three back-to-back operations with new inputs after each accept.
    vc[0] = 16384;  vs[0] = 0;      vt[0] = 32'h0000;
    vc[1] = 0;      vs[1] = 16384;  vt[1] = 32'h4000;
    vc[2] = -16384; vs[2] = -16384; vt[2] = 32'hA000;
    nAcc = 0; nDone = 0; cyc = 0; prevBusy = 1'b0; prevDone = 1'b0; dbl = 1'b0;
    accCyc[0] = 0; accCyc[1] = 0; accCyc[2] = 0;
    cos_in  = 16'(vc[0]);
    sine_in = 16'(vs[0]);
    start   = 1'b1;
    while (nDone < 3 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !prevBusy) begin
        if (nAcc < 3) accCyc[nAcc] = cyc;
        nAcc++;
        if (nAcc < 3) begin
          cos_in  = 16'(vc[nAcc]);
          sine_in = 16'(vs[nAcc]);
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        if (prevDone) dbl = 1'b1;
        if (nDone < 3) checkNear($sformatf("ctrl_theta%0d", nDone), int'(theta), vt[nDone], 4, 1'b1);
        nDone++;
      end
      prevBusy = busy;
      prevDone = done;
    end
    start = 1'b0;
    checkOutput("ctrl_accepts", nAcc, 3);
    checkOutput("ctrl_dones", nDone, 3);
    checkOutput("ctrl_spacing01", accCyc[1] - accCyc[0], THRU);
    checkOutput("ctrl_spacing12", accCyc[2] - accCyc[1], THRU);
    checkOutput("ctrl_done_double", int'(dbl), 0);
    @(posedge clk);
    #1;
    checkOutput("ctrl_done_width", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset pulse at iteration 8 must abort silently and clear all outputs.
    cos_in  = -16'sd16384;
    sine_in = -16'sd16384;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_theta", int'(theta), 0);
    checkOutput("rst_mag", int'(mag), 0);
    doneSeen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("rst_no_done", doneSeen, 0);
    applyStimulus(16'sd0, 16'sd16384, lat, bc);
    checkOutput("post_rst_latency", lat, LAT);
    checkNear("post_rst_theta", int'(theta), 32'h4000, 4, 1'b1);
    checkNear("post_rst_mag", int'(mag), MAG_AX, MAG_AX / 1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_vec.md
# cordic_vec

Iterative CORDIC vectoring engine: the inverse of the rotation-mode sine/cosine generator. It accepts a signed (cos, sine) vector pair and returns the angle in the same 16-bit binary-angle format used for `theta`, plus the vector magnitude. It sits downstream of the sine/cos datapath and recovers phase from sampled quadrature values, using one iteration per clock over 16 iterations.

## Interface
- `ITER`, 16: CORDIC iteration count, range 1..16. The atan table holds 16 entries.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request pulse. Sampled only in IDLE.
- `cos_in` in [0:15]: x component, two's complement, bit 0 = MSB.
- `sine_in` in [0:15]: y component, two's complement, bit 0 = MSB.
- `busy` out 1: high from the accept edge until `done`.
- `done` out 1: one-cycle pulse when results become valid.
- `theta` out [0:15]: angle as an unsigned binary angle. 0x0000 = 0°, 0x4000 = 90°, 0x8000 = 180°; full circle = 65536.
- `mag` out [0:16]: unsigned magnitude.

## Operation
- **States:** IDLE → ITER → DONE → IDLE.
- **IDLE, start=1 (accept edge):**
  - Sign-extend the inputs to 18 bits into x and y.
  - Pre-rotate: if x<0, then x=-x, y=-y, z=0x8000; else z=0.
  - Clear counter i to 0 and go to ITER. `busy` becomes 1.
- **ITER, per edge:**
  - If y≥0: x+=y>>>i, y-=x>>>i, z+=A[i].
  - Else: x-=y>>>i, y+=x>>>i, z-=A[i].
  - Shifts are arithmetic and use the pre-edge values of x and y.
  - i increments; after iteration ITER-1, go to DONE.
- **atan table A[0..15]:** 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- **Widths:**
  - x and y are 18-bit signed, which is enough for gain growth of K·√2 on a full-scale input.
  - z is 16 bits and wraps modulo 2^16; overflow is intentional.
  - x is ≥0 after pre-rotation.
- **DONE edge:** register `theta`=z and `mag`=x[16:0]. Pulse `done`=1 for one cycle, clear `busy`, return to IDLE.
- **Zero vector:** if both inputs are 0 at accept, latch a zero flag. The DONE edge then outputs `theta`=0 and `mag`=0.
- **Output hold:** `theta` and `mag` hold their values until the next DONE.
- **start handling:**
  - `start` while busy is ignored and not queued.
  - `start` held high in IDLE accepts on the first edge.
  - `start` in the same cycle as `done` is not accepted. It is accepted on the following edge if still high.
- **Accuracy:** `theta` is within ±4 LSB of the true atan2. `mag` is within ±0.1% of the ideal scaled value.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `theta`=0, `mag`=0; x, y, z, i, and the zero flag are all 0.
- **Reset mid-operation:** abort with no `done` pulse. All outputs take reset values on the next edge.
- **Latency:** accept edge E → `done` high in the cycle after edge E+ITER+1. For ITER=16, that is 17 clocks.
- **`busy`:** high for exactly ITER+1 cycles.
- **`done`:** falls on the following edge.
- **Throughput:** one result per ITER+2 cycles (back-to-back start).
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Configuration
- **Macro:** `CORDIC_VEC_GAIN_COMP_EN`.
- **Defined:**
  - Insert a GAIN state between ITER and DONE.
  - GAIN computes mag = (x·39797)>>16, which is 1/K ≈ 0.60725 in Q0.16, rounded to nearest.
  - Latency becomes ITER+2 edges, so `done` follows the accept edge by 18 clocks; `busy` lasts ITER+2 cycles.
  - `mag` equals the true |v| in input units.
- **Undefined:**
  - No GAIN state and no multiplier.
  - `mag` = raw x ≈ 1.6468·|v|.

## Test plan
- **Quadrant I axis:** cos=16384, sine=0, start → `done` at 17 clocks; `theta`=0x0000±4; `mag`=26981±27 (compensation off) or 16384±16 (on).
- **90°:** cos=0, sine=16384 → `theta`=0x4000±4; `busy` high for exactly 17 cycles.
- **Third quadrant:** cos=-16384, sine=-16384 → `theta`=0xA000±4 (225°); `mag`=38155±38 (off) or 23170±23 (on).
- **Extremes:**
  - cos=-32768, sine=0 → `theta`=0x8000±4; `mag`=53961±54 (off).
  - cos=0, sine=0 → `theta`=0, `mag`=0.
- **Control:**
  - Hold `start`=1 through three full operations with changing inputs → one accept per ITER+2 cycles; each `done` is exactly one cycle wide.
  - Deassert `rst_n` for one cycle at iteration 8 → next cycle `busy`=0, `done`=0, `theta`=`mag`=0; no `done` pulse follows; a new start completes normally.
